// File: rtl/simd_lane_regfile_if.sv
// simd_lane_regfile_if: write/read port bundle for the multi-lane FP register file
interface simd_lane_regfile_if #(
  parameter int width_p  = 33,
  parameter int els_p    = 32,
  parameter int lanes_p  = 4,
  parameter int num_rs_p = 3
) ();
  localparam int addr_width_lp = $clog2(els_p);
  logic                                             ready_o;
  logic [lanes_p-1:0]                               w_v_i;
  logic [addr_width_lp-1:0]                         w_addr_i;
  logic [lanes_p-1:0][width_p-1:0]                  w_data_i;
  logic [num_rs_p-1:0]                              r_v_i;
  logic [num_rs_p-1:0][addr_width_lp-1:0]           r_addr_i;
  logic [num_rs_p-1:0][lanes_p-1:0][width_p-1:0]    r_data_o;
  modport master (input ready_o, r_data_o, output w_v_i, w_addr_i, w_data_i, r_v_i, r_addr_i);
  modport slave (output ready_o, r_data_o, input w_v_i, w_addr_i, w_data_i, r_v_i, r_addr_i);
endinterface

// File: rtl/simd_lane_regfile.sv
// simd_lane_regfile: multi-lane FP register file with registered write-first reads and post-reset clear
module simd_lane_regfile #(
  parameter int width_p  = 33,
  parameter int els_p    = 32,
  parameter int lanes_p  = 4,
  parameter int num_rs_p = 3
) (
  input logic                  clk_i,
  input logic                  reset_i,
  simd_lane_regfile_if.slave   rf_io
);
  localparam int addr_width_lp = $clog2(els_p);
  localparam logic [addr_width_lp:0] els_w = (addr_width_lp+1)'(els_p);
  localparam logic [addr_width_lp-1:0] last_w = addr_width_lp'(els_p - 1);
  typedef enum logic [1:0] {e_clear, e_ready} state_e;
  state_e state_q, state_d;
  logic [addr_width_lp-1:0] clr_cnt_q, clr_cnt_d;
  logic [lanes_p-1:0][width_p-1:0] mem_q [els_p];
  logic [num_rs_p-1:0][lanes_p-1:0][width_p-1:0] r_data_q, r_data_d;
  logic ready_s, wr_en;
  assign ready_s = state_q == e_ready;
  assign wr_en = ready_s && ({1'b0, rf_io.w_addr_i} < els_w);
  assign rf_io.ready_o = ready_s;
  assign rf_io.r_data_o = r_data_q;
  // Clear walks entries 0..els_p-1 once, then parks in READY
  always_comb begin
    state_d = (state_q == e_clear && clr_cnt_q == last_w) ? e_ready : state_q;
    clr_cnt_d = (state_q == e_clear && clr_cnt_q != last_w) ? clr_cnt_q + addr_width_lp'(1) : clr_cnt_q;
  end
  // State and clear counter; reset restarts the clear from entry 0
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= e_clear;
      clr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end
  // Storage: clear zeroes a whole entry, normal writes update only enabled lanes
  always_ff @(posedge clk_i) begin
    if (!reset_i && state_q == e_clear)
      mem_q[clr_cnt_q] <= '0;
    else if (!reset_i && wr_en)
      for (int l = 0; l < lanes_p; l++)
        if (rf_io.w_v_i[l]) mem_q[rf_io.w_addr_i][l] <= rf_io.w_data_i[l];
  end
  // Read mux with per-lane bypass of same-edge writes; out-of-range addresses read zero
  always_comb begin
    r_data_d = r_data_q;
    for (int p = 0; p < num_rs_p; p++)
      for (int l = 0; l < lanes_p; l++)
        if (ready_s && rf_io.r_v_i[p])
          r_data_d[p][l] = !({1'b0, rf_io.r_addr_i[p]} < els_w) ? '0 :
                           (wr_en && rf_io.w_v_i[l] && rf_io.w_addr_i == rf_io.r_addr_i[p]) ? rf_io.w_data_i[l] :
                           mem_q[rf_io.r_addr_i[p]][l];
  end
  // Registered read ports hold their value while disabled
  always_ff @(posedge clk_i) begin
    if (reset_i) r_data_q <= '0;
    else r_data_q <= r_data_d;
  end
endmodule
